// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB4 completer wrapping a byte-strobed word memory with wait states and PSLVERR
module apb_mem_slave #(
   parameter int                     MEM_DEPTH   = 256,
   parameter int                     DATA_WIDTH  = 32,
   parameter int                     PADDR_WIDTH = 32,
   parameter logic [PADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int                     WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [PADDR_WIDTH-1:0]  paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int LSB    = $clog2(STRB_W);

   // Low byte-address bits that must be zero for a word-aligned access.
   localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK = PADDR_WIDTH'(STRB_W - 1);
   localparam logic [PADDR_WIDTH-1:0] DEPTH_C    = PADDR_WIDTH'(MEM_DEPTH);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [PADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                     write_q, write_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [STRB_W-1:0]        strb_q, strb_d;
   logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0]    mem_d [MEM_DEPTH];

   logic [PADDR_WIDTH-1:0]   off;
   logic [PADDR_WIDTH-1:0]   idx_full;
   logic [IDX_W-1:0]         idx;
   logic                     err_range, err_align, err_strb, err_any;
   logic                     commit;

   // Decode the latched address against the window; all error sources fold into err_any.
   always_comb begin
      off       = addr_q - BASE_ADDR;
      idx_full  = off >> LSB;
      idx       = idx_full[IDX_W-1:0];
      err_range = (addr_q < BASE_ADDR) || (idx_full >= DEPTH_C);
      err_align = (off & ALIGN_MASK) != '0;
      err_strb  = !write_q && (strb_q != '0);
      err_any   = err_range || err_align || err_strb;
   end

   // Response outputs are combinational so pready can rise in the first access cycle.
   always_comb begin
      pready  = (state_q == ACCESS) && (cnt_q == 4'd0) && psel && penable;
      pslverr = pready && err_any;
      prdata  = (pready && !write_q && !err_any) ? mem_q[idx] : '0;
   end

   // Next-state logic: capture the request at setup, count wait states, complete or abort.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               addr_d  = paddr;
               write_d = pwrite;
               wdata_d = pwdata;
               strb_d  = pstrb;
               cnt_d   = 4'(WAIT_STATES);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel) begin
               // Requester withdrew: drop the transfer without a response.
               state_d = IDLE;
            end else if (penable) begin
               if (cnt_q == 4'd0) begin
                  commit  = write_q && !err_any;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte-lane merge of the latched write data into the addressed word.
   always_comb begin
      mem_d = mem_q;
      if (commit) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (strb_q[i]) begin
               mem_d[idx][8*i +: 8] = wdata_q[8*i +: 8];
            end
         end
      end
   end

   // Control and request registers; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
      end
   end

   // Memory array; reset clears every word and takes priority over a same-edge commit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule
